// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: transmit/latch FSM plus pixel, bit and pattern-slot counters.
// Latency: a start edge is seen on one clock and TRANSMIT with zeroed counters is visible on the next; all outputs are registered.
// Backpressure: none; the encoder consumes the counters every cycle, and dropping run aborts the frame into a full latch period.
module anton_neopixel_sequencer #(
   parameter int BUFFER_END   = 31,
   parameter int RESET_CYCLES = 400,
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
   input  logic                   clk6_4mhz,
   input  logic                   syncReset,
   input  logic                   reg_ctrl_run,
   input  logic                   reg_ctrl_loop,
   input  logic                   reg_ctrl_32bit,
   input  logic [BUFFER_BITS-1:0] reg_max,
   output logic                   state,
   output logic [BUFFER_BITS-1:0] pixel_index,
   output logic [4:0]             pixel_bit_index,
   output logic [2:0]             bit_pattern_index,
   output logic                   stream_sync,
   output logic                   frame_done
);

   localparam int LATCH_BITS = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [LATCH_BITS-1:0]  LATCH_LAST = LATCH_BITS'(RESET_CYCLES - 1);
   localparam logic [LATCH_BITS-1:0]  LATCH_ONE  = LATCH_BITS'(1);
   localparam logic [BUFFER_BITS-1:0] END_IDX    = BUFFER_BITS'(BUFFER_END);
   localparam logic [BUFFER_BITS-1:0] IDX_ONE    = BUFFER_BITS'(1);
   localparam logic [BUFFER_BITS-3:0] GRP_ONE    = (BUFFER_BITS - 2)'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TRANSMIT = 2'd1,
      S_LATCH    = 2'd2
   } fsm_t;

   fsm_t                   fsm_q, fsm_d;
   logic                   run_q, run_d;
   logic                   mode32_l_q, mode32_l_d;
   logic [BUFFER_BITS-1:0] max_l_q, max_l_d;
   logic [BUFFER_BITS-1:0] pixel_index_q, pixel_index_d;
   logic [4:0]             pixel_bit_q, pixel_bit_d;
   logic [2:0]             pattern_q, pattern_d;
   logic [LATCH_BITS-1:0]  latch_cnt_q, latch_cnt_d;
   logic                   state_q, state_d;
   logic                   stream_sync_q, stream_sync_d;
   logic                   frame_done_q, frame_done_d;

   logic                   start;
   logic                   last_pixel;
   logic [BUFFER_BITS-1:0] next_index;

   // Last-pixel test and next pixel address; the buffer-end terms stop the index from wrapping when max exceeds the buffer.
   always_comb begin
      start = reg_ctrl_run & ~run_q;
      if (mode32_l_q) begin
         last_pixel = (pixel_index_q[BUFFER_BITS-1:2] == max_l_q[BUFFER_BITS-1:2]) ||
                      (pixel_index_q[BUFFER_BITS-1:2] == END_IDX[BUFFER_BITS-1:2]);
         next_index = {pixel_index_q[BUFFER_BITS-1:2] + GRP_ONE, 2'b00};
      end else begin
         last_pixel = (pixel_index_q == max_l_q) || (pixel_index_q == END_IDX);
         next_index = pixel_index_q + IDX_ONE;
      end
   end

   // Next-state and counter logic for the IDLE / TRANSMIT / LATCH sequencer.
   always_comb begin
      fsm_d         = fsm_q;
      run_d         = reg_ctrl_run;
      mode32_l_d    = mode32_l_q;
      max_l_d       = max_l_q;
      pixel_index_d = pixel_index_q;
      pixel_bit_d   = pixel_bit_q;
      pattern_d     = pattern_q;
      latch_cnt_d   = latch_cnt_q;
      frame_done_d  = 1'b0;

      case (fsm_q)
         S_IDLE: begin
            pixel_index_d = '0;
            pixel_bit_d   = '0;
            pattern_d     = '0;
            latch_cnt_d   = '0;
            if (start) begin
               fsm_d      = S_TRANSMIT;
               mode32_l_d = reg_ctrl_32bit;
               max_l_d    = reg_max;
            end
         end
         S_TRANSMIT: begin
            if (!reg_ctrl_run) begin
               fsm_d         = S_LATCH;
               pixel_index_d = '0;
               pixel_bit_d   = '0;
               pattern_d     = '0;
               latch_cnt_d   = '0;
            end else begin
               pattern_d = pattern_q + 3'd1;
               if (pattern_q == 3'd7) begin
                  if (pixel_bit_q == 5'd23) begin
                     pixel_bit_d = '0;
                     if (last_pixel) begin
                        fsm_d         = S_LATCH;
                        pixel_index_d = '0;
                        latch_cnt_d   = '0;
                     end else begin
                        pixel_index_d = next_index;
                     end
                  end else begin
                     pixel_bit_d = pixel_bit_q + 5'd1;
                  end
               end
            end
         end
         S_LATCH: begin
            if (latch_cnt_q == LATCH_LAST) begin
               latch_cnt_d = '0;
               if (reg_ctrl_loop && reg_ctrl_run) begin
                  fsm_d      = S_TRANSMIT;
                  mode32_l_d = reg_ctrl_32bit;
                  max_l_d    = reg_max;
               end else begin
                  fsm_d        = S_IDLE;
                  frame_done_d = 1'b1;
               end
            end else begin
               latch_cnt_d = latch_cnt_q + LATCH_ONE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase

      state_d       = (fsm_d != S_TRANSMIT);
      stream_sync_d = (fsm_d == S_LATCH) && (latch_cnt_d == LATCH_LAST);
   end

   // State registers; synchronous reset overrides everything.
   always_ff @(posedge clk6_4mhz) begin
      if (syncReset) begin
         fsm_q         <= S_IDLE;
         run_q         <= 1'b0;
         mode32_l_q    <= 1'b0;
         max_l_q       <= '0;
         pixel_index_q <= '0;
         pixel_bit_q   <= '0;
         pattern_q     <= '0;
         latch_cnt_q   <= '0;
         state_q       <= 1'b1;
         stream_sync_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         run_q         <= run_d;
         mode32_l_q    <= mode32_l_d;
         max_l_q       <= max_l_d;
         pixel_index_q <= pixel_index_d;
         pixel_bit_q   <= pixel_bit_d;
         pattern_q     <= pattern_d;
         latch_cnt_q   <= latch_cnt_d;
         state_q       <= state_d;
         stream_sync_q <= stream_sync_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign state             = state_q;
   assign pixel_index       = pixel_index_q;
   assign pixel_bit_index   = pixel_bit_q;
   assign bit_pattern_index = pattern_q;
   assign stream_sync       = stream_sync_q;
   assign frame_done        = frame_done_q;

endmodule
